imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the core's instruction memory. It is the write side of the memory that the fetch path only reads.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written sequentially from word address 0, and a trailing checksum is verified.
- Holds the core in reset-hold until a load completes cleanly, so programs can be loaded at runtime instead of only from a hex file at elaboration.

Parameters:
DEPTH, 64, instruction memory size in words; maximum loadable word count.
ADDR_W, 32, width of the write byte address.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  single-cycle pulse; begins a load when not already loading.
in_valid  input  1  byte stream valid.
in_data  input  8  byte stream data.
in_ready  output  1  loader accepts the byte this cycle; transfer occurs when in_valid && in_ready.
wr_en  output  1  one-cycle instruction memory write strobe.
wr_addr  output  ADDR_W  byte address of the write, always word-aligned (word_idx << 2).
wr_data  output  32  instruction word to write.
core_hold  output  1  high keeps the core stalled/reset.
done  output  1  one-cycle pulse on successful load.
error  output  1  sticky error flag.

Behaviour:
- Reset (reset==0, asynchronous) values:
  - Outputs: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0, core_hold=1.
  - State: IDLE; counters, buffer and checksum = 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes with LSB first per word, then CSUM.
  - CSUM = XOR of all preceding bytes, length bytes included.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR:
  - in_ready=0.
  - start → LEN0; clear error, word_idx, byte_idx and checksum; core_hold=1 the next cycle.
- LEN0: in_ready=1. On a transfer, len[7:0]=byte and checksum^=byte; → LEN1.
- LEN1: in_ready=1. On a transfer, len[15:8]=byte and checksum^=byte; then:
  - N==0 → CSUM.
  - N>DEPTH → ERR.
  - otherwise → DATA.
- DATA: in_ready=1. Each transfer places the byte into buffer lane byte_idx, sets checksum^=byte and increments byte_idx (2-bit, wraps).
  - On the transfer with byte_idx==3:
    - Next cycle wr_en=1, wr_addr=word_idx<<2, wr_data=assembled word.
    - word_idx increments.
    - If this was word N-1 → CSUM.
  - wr_en is high exactly one cycle per word, with no backpressure on the byte stream. A byte may be accepted in the same cycle wr_en is high.
- CSUM: in_ready=1. On a transfer:
  - byte==checksum → DONE: done=1 for one cycle, core_hold=0.
  - mismatch → ERR: error=1, core_hold stays 1.
- ERR:
  - error remains 1 until the next start or reset.
  - Words already written are not rolled back; the core remains held.
- Bytes presented with in_ready=0 are not consumed.
- in_valid low cycles stall any state without effect.
- start asserted in LEN0/LEN1/DATA/CSUM is ignored.
- start in the same cycle as a DONE/ERR entry is ignored; it takes effect only from a settled IDLE/DONE/ERR state.
- Reset mid-load: immediate return to IDLE with all reset values. Partially written memory contents are left as is; core_hold=1.
- word_idx never exceeds DEPTH-1, and wr_addr never exceeds (DEPTH-1)*4.

Test Plan:
- Two-word load: start, then bytes 02 00 93 81 A0 00 23 A4 60 00 57 with in_valid held high.
  - Writes: wr_en pulses with (0x0, 0x00A08193), then (0x4, 0x0060A423).
  - Then done pulses once, core_hold falls to 0 and error=0.
- Same stream with in_valid deasserted for 3 cycles between every byte → identical writes and completion; no byte is dropped or duplicated.
- Oversize: start, bytes 41 00 (N=65, DEPTH=64) → ERR: no wr_en ever, error=1, core_hold=1, in_ready=0.
- Bad checksum: the two-word stream with final byte 58 → both writes occur, then error=1, done never asserts, core_hold=1. A following start clears error.
- Empty load: start, bytes 00 00 00 → no wr_en, done pulse, core_hold=0.
- Reset mid-DATA: assert reset after 5 data bytes of the two-word stream → outputs return to reset values immediately, only the word at 0x0 has been written, and a fresh start plus full stream completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: assembles little-endian words from a byte
// stream, writes them from address 0 and releases the core only after a good checksum.
//
// state | meaning
// IDLE  | post-reset, core held, waiting for start
// LEN0  | expecting word count low byte
// LEN1  | expecting word count high byte
// DATA  | receiving instruction bytes, one write per 4 bytes
// CSUM  | expecting XOR checksum byte
// DONE  | load verified, core released
// ERR   | oversize length or bad checksum, core held
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              error
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [AW-1:0]     word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       buf_q, buf_d;
    logic [7:0]        csum_q, csum_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              core_hold_q, core_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic        xfer;
    logic [15:0] len_new;
    logic        last_word;

    assign xfer      = in_valid && in_ready_q;
    assign len_new   = {in_data, len_q[7:0]};
    assign last_word = ({{(16-AW){1'b0}}, word_idx_q} == (len_q - 16'd1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        buf_d       = buf_q;
        csum_d      = csum_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        core_hold_d = core_hold_q;
        done_d      = 1'b0;
        error_d     = error_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d     = LEN0;
                    len_d       = 16'd0;
                    word_idx_d  = '0;
                    byte_idx_d  = 2'd0;
                    csum_d      = 8'd0;
                    error_d     = 1'b0;
                    core_hold_d = 1'b1;
                end
            end
            LEN0: begin
                if (xfer) begin
                    len_d   = {len_q[15:8], in_data};
                    csum_d  = csum_q ^ in_data;
                    state_d = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    len_d  = len_new;
                    csum_d = csum_q ^ in_data;
                    if (len_new == 16'd0) begin
                        state_d = CSUM;
                    end else if ({1'b0, len_new} > DEPTH_L) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    buf_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // lane 3 goes straight into the write word, saving a cycle
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'({word_idx_q, 2'b00});
                        wr_data_d = {in_data, buf_q[23:0]};
                        if (last_word) begin
                            state_d = CSUM;
                        end else begin
                            word_idx_d = word_idx_q + AW'(1);
                        end
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LEN0) || (state_d == LEN1) ||
                     (state_d == DATA) || (state_d == CSUM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= 16'd0;
            word_idx_q  <= '0;
            byte_idx_q  <= 2'd0;
            buf_q       <= 32'd0;
            csum_q      <= 8'd0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'd0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            buf_q       <= buf_d;
            csum_q      <= csum_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed stream table, multi-cycle corner sequences and
// random streams compared against a stream-level reference model.
module tb_imem_loader;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    typedef logic [7:0]  bq_t[$];
    typedef logic [63:0] wq_t[$];

    typedef struct {
        string       name;
        int          nb;
        logic [95:0] bytes;
        int          gap;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          ed;
        bit          ee;
    } vec_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              core_hold;
    logic              done;
    logic              error;

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    wq_t  wq;
    vec_t vt[5];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && wr_en) begin
            wq.push_back({wr_addr, wr_data});
            chk("wr_addr_aligned_in_range",
                64'((wr_addr[1:0] == 2'b00) && (wr_addr <= 32'((DEPTH-1)*4))), 64'd1);
        end
        if (reset && done) done_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // Reference: decode the stream as a whole rather than byte by byte.
    task automatic model(input bq_t s, output wq_t ew, output bit ed, output bit ee);
        int n;
        logic [7:0] x;
        ew = {};
        ed = 0;
        ee = 0;
        n = int'({s[1], s[0]});
        if (n > DEPTH) begin
            ee = 1;
            return;
        end
        for (int k = 0; k < n; k++)
            ew.push_back({32'(k*4), s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]});
        x = 8'h00;
        for (int i = 0; i < 2 + 4*n; i++) x ^= s[i];
        if (s[2+4*n] == x) ed = 1;
        else ee = 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_load(input string nm, input bq_t s, input int gap);
        wq.delete();
        done_cnt = 0;
        pulse_start();
        chk({nm, ".start_hold"}, 64'(core_hold), 64'd1);
        chk({nm, ".start_err_clr"}, 64'(error), 64'd0);
        chk({nm, ".start_ready"}, 64'(in_ready), 64'd1);
        foreach (s[i]) send_byte(s[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_result(input string nm, input wq_t ew, input bit ed, input bit ee);
        chk({nm, ".nwrites"}, 64'(wq.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wq.size(); i++)
            chk($sformatf("%s.write%0d", nm, i), wq[i], ew[i]);
        chk({nm, ".done_cnt"}, 64'(done_cnt), 64'(ed));
        chk({nm, ".error"}, 64'(error), 64'(ee));
        chk({nm, ".core_hold"}, 64'(core_hold), 64'(!ed));
        chk({nm, ".in_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic set_vec(input int i, input string nm, input int nb, input logic [95:0] by,
                           input int gap, input int nw, input bit ed, input bit ee);
        vt[i].name  = nm;
        vt[i].nb    = nb;
        vt[i].bytes = by;
        vt[i].gap   = gap;
        vt[i].nw    = nw;
        vt[i].w0    = 32'h00A08193;
        vt[i].w1    = 32'h0060A423;
        vt[i].ed    = ed;
        vt[i].ee    = ee;
    endtask

    initial begin
        bq_t s;
        wq_t ew;
        bit  ed, ee;

        set_vec(0, "two_word",     11, 96'h57_00_60_A4_23_00_A0_81_93_00_02, 0, 2, 1, 0);
        set_vec(1, "two_word_gap", 11, 96'h57_00_60_A4_23_00_A0_81_93_00_02, 3, 2, 1, 0);
        set_vec(2, "oversize",      2, 96'h00_41,                            0, 0, 0, 1);
        set_vec(3, "bad_csum",     11, 96'h58_00_60_A4_23_00_A0_81_93_00_02, 0, 2, 0, 1);
        set_vec(4, "empty",         3, 96'h00_00_00,                         0, 0, 1, 0);

        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {in_ready, wr_en, wr_addr, wr_data, core_hold, done, error},
            {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            s = {};
            for (int j = 0; j < vt[i].nb; j++) s.push_back(vt[i].bytes[j*8 +: 8]);
            ew = {};
            for (int k = 0; k < vt[i].nw; k++)
                ew.push_back({32'(k*4), (k == 0) ? vt[i].w0 : vt[i].w1});
            run_load(vt[i].name, s, vt[i].gap);
            check_result(vt[i].name, ew, vt[i].ed, vt[i].ee);
        end

        // error clears on start even when the previous load failed
        s = {8'h02, 8'h00, 8'h93, 8'h81, 8'hA0, 8'h00, 8'h23, 8'hA4, 8'h60, 8'h00, 8'h58};
        run_load("bad_csum2", s, 0);
        chk("bad_csum2.error_set", 64'(error), 64'd1);
        pulse_start();
        chk("restart.error_clr", 64'(error), 64'd0);
        chk("restart.hold", 64'(core_hold), 64'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 1);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("restart.done_hold", 64'(core_hold), 64'd0);

        // start coinciding with DONE entry must not relaunch
        wq.delete();
        done_cnt = 0;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_at_done.done", 64'(done), 64'd1);
        @(negedge clk);
        chk("start_at_done.ignored_ready", 64'(in_ready), 64'd0);
        chk("start_at_done.ignored_hold", 64'(core_hold), 64'd0);
        chk("start_at_done.done_once", 64'(done_cnt), 64'd1);

        // reset after 5 data bytes
        wq.delete();
        done_cnt = 0;
        pulse_start();
        s = {8'h02, 8'h00, 8'h93, 8'h81, 8'hA0, 8'h00, 8'h23};
        foreach (s[i]) send_byte(s[i], 0);
        reset = 1'b0;
        #1;
        chk("mid_reset.outputs", {in_ready, wr_en, wr_addr, wr_data, core_hold, done, error},
            {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0});
        chk("mid_reset.nwrites", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) chk("mid_reset.write0", wq[0], {32'd0, 32'h00A08193});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        s = {8'h02, 8'h00, 8'h93, 8'h81, 8'hA0, 8'h00, 8'h23, 8'hA4, 8'h60, 8'h00, 8'h57};
        model(s, ew, ed, ee);
        run_load("after_reset", s, 0);
        check_result("after_reset", ew, ed, ee);

        for (int it = 0; it < 30; it++) begin
            int n, r;
            logic [15:0] nl;
            logic [7:0]  x;
            r = int'($urandom_range(0, 19));
            if (r < 14)       n = int'($urandom_range(1, 6));
            else if (r == 14) n = 0;
            else if (r == 15) n = DEPTH;
            else if (r == 16) n = DEPTH + 1;
            else if (r == 17) n = DEPTH - 1;
            else              n = int'($urandom_range(DEPTH + 2, 65535));
            nl = 16'(n);
            s = {nl[7:0], nl[15:8]};
            if (n <= DEPTH) begin
                for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom));
                x = 8'h00;
                foreach (s[i]) x ^= s[i];
                if ($urandom_range(0, 4) == 0) x ^= 8'(1 << $urandom_range(0, 7));
                s.push_back(x);
            end
            model(s, ew, ed, ee);
            run_load($sformatf("rand%0d", it), s, -1);
            check_result($sformatf("rand%0d", it), ew, ed, ee);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
